corescore_stream_arbiter: RTL and testbench
===========================================

Name: corescore_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one 8-bit AXI-Stream sink (the UART emitter) between NUM_SOURCES byte-stream producers.
- Typical producers: the corescorecore message stream plus debug or status message sources.
- Once a source is granted, it keeps the sink until its tlast beat is accepted, so packets are never interleaved.
- One registered output stage gives full throughput with 1-cycle latency.

Parameters:
- NUM_SOURCES, 4, number of requesting streams (2..16).
- SRC_W, $clog2(NUM_SOURCES), width of the grant index (derived, not overridden).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tdata  in  8*NUM_SOURCES  source k byte on bits [8k+7:8k].
- i_tlast  in  NUM_SOURCES  last byte of packet, per source.
- i_tvalid  in  NUM_SOURCES  byte valid, per source.
- o_tready  out  NUM_SOURCES  byte accepted, per source; at most one bit set (onehot0).
- o_tdata  out  8  byte to sink.
- o_tlast  out  1  last byte of packet to sink.
- o_tvalid  out  1  output register holds a byte.
- i_tready  in  1  sink accepts the byte.
- o_grant  out  SRC_W  index of the current or most recent owner.
- o_busy  out  1  state is GRANT.

Behaviour:
- Reset (async assert, sync-free deassert handled by the top): state=ARB, o_tvalid=0, o_tdata=0, o_tlast=0, o_tready=0, o_grant=0, last pointer=NUM_SOURCES-1, so source 0 has first priority.
- Reset asserted mid-packet clears everything immediately. The partial packet is abandoned; the sink sees no tlast for it.
- States:
  - ARB: if any i_tvalid is set, select the first set bit scanning from last+1 upward, wrapping modulo NUM_SOURCES. Register it into o_grant and the last pointer, then go to GRANT on the next cycle. If no i_tvalid is set, stay in ARB. o_tready=0 throughout ARB.
  - GRANT: o_tready[o_grant] = !o_tvalid | i_tready. All other o_tready bits are 0.
- Input handshake (i_tvalid[g] & o_tready[g]): load i_tdata[g] and i_tlast[g] into the output register and set o_tvalid=1.
- Output handshake (o_tvalid & i_tready) with no input handshake in the same cycle: clear o_tvalid.
- Simultaneous input and output handshake: reload the register; o_tvalid stays 1.
- Accepted input beat with tlast=1: next state is ARB.
  - The output register may still hold that byte; it drains independently.
  - ARB may start the next grant while the byte drains, but no new byte is accepted until the register is free or being emptied.
- Arbitration bubble: exactly one cycle (the ARB cycle) between a tlast acceptance and the next grant's first possible acceptance.
- Latency: a byte accepted in cycle n appears on o_tdata and o_tvalid in cycle n+1.
- Sustained throughput within a packet is 1 byte/cycle when i_tready=1.
- Output stability: while o_tvalid=1 and i_tready=0, o_tdata and o_tlast hold constant.
- Source stalls: a granted source that deasserts i_tvalid mid-packet keeps the grant indefinitely. There is no timeout; producers must not stall forever.
- Single-byte packet (tlast on first beat) is legal: grant, one beat, back to ARB.
- Only one requester: it is re-granted after each bubble, so there is no starvation.
- Fairness: with all sources continuously requesting, grant order is 0,1,2,...,N-1,0,...
- Non-requesting sources are skipped without a cycle penalty.
- o_busy=1 exactly when the state is GRANT.

Decomposition:
- Shared package corescore_pkg:
  - localparam AXIS_DATA_W=8;
  - state enum {ARB, GRANT}.
- Natural sub-module: corescore_rr_pick, combinational.
  - Inputs: request vector, last pointer.
  - Outputs: found flag, selected index.
  - Implementation: double-width rotate plus priority encode.
- Output register and FSM stay in the top block.

Test Plan:
- Reset, then source 2 sends 3 bytes 0x41,0x42,0x43 (tlast on 0x43) with i_tready=1 -> one ARB cycle, o_grant=2, bytes appear on o_tdata on consecutive cycles, o_tlast=1 only with 0x43, state returns to ARB.
- All 4 sources continuously send 2-byte packets -> grant sequence 0,1,2,3,0; no byte from one packet appears between the bytes of another.
- i_tready toggles 1,0,0,1 during a 4-byte packet -> o_tdata and o_tlast stable while stalled; all 4 bytes delivered in order with none dropped or duplicated; o_tready[g] low whenever o_tvalid=1 and i_tready=0.
- Sources 1 and 3 request, last grant=1 -> next grant is 3, then 1; sources 0 and 2 are never granted and their o_tready stays 0.
- i_rst_n pulsed low after byte 2 of a 5-byte packet -> o_tvalid=0 and o_tready=0 in the same cycle (async); after release, source 0 wins first if requesting.
- Single-byte packets from source 0 only, with i_tready=1 -> one byte accepted every 2 cycles (grant/bubble alternation), o_tlast=1 on every byte.

Source files
------------

// File: rtl/corescore_pkg.sv
// ============================================================================
//  corescore_pkg : shared types and constants for the corescore stream arbiter
//  Revision 1.0  : initial release
// ============================================================================
`default_nettype none

package corescore_pkg;

    localparam int AXIS_DATA_W = 8;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage : corescore_pkg

`default_nettype wire

// File: rtl/corescore_rr_pick.sv
// ============================================================================
//  corescore_rr_pick : combinational round-robin picker, first request after
//                      the last pointer, wrapping modulo NUM_SOURCES
//  Revision 1.0      : initial release
// ============================================================================
`default_nettype none

module corescore_rr_pick
    import corescore_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int SRC_W       = $clog2(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] i_req,
    input  logic [SRC_W-1:0]       i_last,
    output logic                   o_found,
    output logic [SRC_W-1:0]       o_idx
);

    // Two extra bits hold last+1+offset, which can reach 2*NUM_SOURCES-1.
    localparam int SUM_W = SRC_W + 2;

    logic [2*NUM_SOURCES-1:0] w_dbl;
    logic [NUM_SOURCES-1:0]   w_rot;
    logic [SUM_W-1:0]         w_start;
    logic [SUM_W-1:0]         w_off;
    logic [SUM_W-1:0]         w_sum;
    logic [SUM_W-1:0]         w_wrap;

    always_comb begin
        w_start = SUM_W'(i_last) + SUM_W'(1);
        w_dbl   = {i_req, i_req};
        w_rot   = NUM_SOURCES'(w_dbl >> w_start);
        o_found = |i_req;
        w_off   = '0;
        for (int j = NUM_SOURCES - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = SUM_W'(j);
            end
        end
        w_sum  = w_start + w_off;
        w_wrap = (w_sum >= SUM_W'(NUM_SOURCES)) ? (w_sum - SUM_W'(NUM_SOURCES)) : w_sum;
        o_idx  = w_wrap[SRC_W-1:0];
    end

endmodule : corescore_rr_pick

`default_nettype wire

// File: rtl/corescore_stream_arbiter.sv
// ============================================================================
//  corescore_stream_arbiter : packet-granular round-robin arbiter sharing one
//                             8-bit AXI-Stream sink between NUM_SOURCES inputs
//  Revision 1.0             : initial release
// ============================================================================
`default_nettype none

module corescore_stream_arbiter
    import corescore_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int SRC_W       = $clog2(NUM_SOURCES)
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [AXIS_DATA_W*NUM_SOURCES-1:0] i_tdata,
    input  logic [NUM_SOURCES-1:0]             i_tlast,
    input  logic [NUM_SOURCES-1:0]             i_tvalid,
    output logic [NUM_SOURCES-1:0]             o_tready,
    output logic [AXIS_DATA_W-1:0]             o_tdata,
    output logic                               o_tlast,
    output logic                               o_tvalid,
    input  logic                               i_tready,
    output logic [SRC_W-1:0]                   o_grant,
    output logic                               o_busy
);

    state_e                   state_q, state_d;
    logic [SRC_W-1:0]         grant_q, grant_d;
    logic [SRC_W-1:0]         last_q,  last_d;
    logic [AXIS_DATA_W-1:0]   tdata_q, tdata_d;
    logic                     tlast_q, tlast_d;
    logic                     tvalid_q, tvalid_d;

    logic [AXIS_DATA_W-1:0]   w_src_data [NUM_SOURCES];
    logic                     w_found;
    logic [SRC_W-1:0]         w_pick;
    logic [NUM_SOURCES-1:0]   w_tready;
    logic                     w_can_load;
    logic                     w_in_hs;

    for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_unpack
        assign w_src_data[k] = i_tdata[AXIS_DATA_W*k +: AXIS_DATA_W];
    end

    corescore_rr_pick #(
        .NUM_SOURCES (NUM_SOURCES),
        .SRC_W       (SRC_W)
    ) u_pick (
        .i_req   (i_tvalid),
        .i_last  (last_q),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        w_tready   = '0;
        w_in_hs    = 1'b0;
        // The output register can take a byte when empty or draining this cycle.
        w_can_load = !tvalid_q || i_tready;

        case (state_q)
            ARB: begin
                if (w_found) begin
                    grant_d = w_pick;
                    last_d  = w_pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                w_tready[grant_q] = w_can_load;
                w_in_hs           = i_tvalid[grant_q] && w_can_load;
                if (w_in_hs && i_tlast[grant_q]) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase

        if (w_in_hs) begin
            tdata_d  = w_src_data[grant_q];
            tlast_d  = i_tlast[grant_q];
            tvalid_d = 1'b1;
        end else if (tvalid_q && i_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ARB;
            grant_q  <= '0;
            last_q   <= SRC_W'(NUM_SOURCES - 1);
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign o_tready = w_tready;
    assign o_tdata  = tdata_q;
    assign o_tlast  = tlast_q;
    assign o_tvalid = tvalid_q;
    assign o_grant  = grant_q;
    assign o_busy   = (state_q == GRANT);

endmodule : corescore_stream_arbiter

`default_nettype wire

// File: tb/tb_corescore_stream_arbiter.sv
// ============================================================================
//  tb_corescore_stream_arbiter : scoreboard bench for the stream arbiter
//  Revision 1.0                : initial release
// ============================================================================
`default_nettype none

module tb_corescore_stream_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       first;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [8*N-1:0] i_tdata;
    logic [N-1:0]   i_tlast;
    logic [N-1:0]   i_tvalid;
    logic [N-1:0]   o_tready;
    logic [7:0]     o_tdata;
    logic           o_tlast;
    logic           o_tvalid;
    logic           i_tready;
    logic [1:0]     o_grant;
    logic           o_busy;

    beat_t drv_q [N][$];
    beat_t exp_q [N][$];
    int    pkt_order [$];
    int    beat_cyc [$];
    int    tr_pat [$];

    int       n_checks = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    bit       rnd_mode = 1'b0;
    bit       watch_en = 1'b0;
    logic [N-1:0] watch_mask = '0;

    corescore_stream_arbiter #(.NUM_SOURCES(N)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready),
        .o_grant  (o_grant),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic send_pkt(input int k, input int len, input int base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = 8'(base + i);
            b.last  = (i == len - 1);
            b.first = (i == 0);
            drv_q[k].push_back(b);
            exp_q[k].push_back(b);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += exp_q[k].size();
        return s;
    endfunction

    task automatic flush();
        for (int k = 0; k < N; k++) begin
            drv_q[k].delete();
            exp_q[k].delete();
        end
        tr_pat.delete();
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (pending() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("drain_complete", pending(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Source driver: pops a beat after the handshake seen on the previous cycle.
    initial begin
        logic [N-1:0] fire;
        i_tvalid = '0;
        i_tdata  = '0;
        i_tlast  = '0;
        i_tready = 1'b1;
        forever begin
            @(negedge clk);
            fire = i_tvalid & o_tready;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (fire[k] && drv_q[k].size() > 0) void'(drv_q[k].pop_front());
            end
            for (int k = 0; k < N; k++) begin
                if (drv_q[k].size() > 0) begin
                    i_tvalid[k]       = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                    i_tdata[8*k +: 8] = drv_q[k][0].data;
                    i_tlast[k]        = drv_q[k][0].last;
                end else begin
                    i_tvalid[k] = 1'b0;
                end
            end
            if (tr_pat.size() > 0) i_tready = (tr_pat.pop_front() != 0);
            else if (rnd_mode)     i_tready = ($urandom_range(0, 9) < 7);
            else                   i_tready = 1'b1;
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each output beat.
    bit         in_pkt = 1'b0;
    bit         prev_stall = 1'b0;
    bit         found;
    int         cur_src = 0;
    logic [7:0] prev_data;
    logic       prev_last;
    beat_t      e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_pkt     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("tready_onehot0", 32'($countones(o_tready) <= 1), 1);
            if (o_tvalid && !i_tready) check("tready_low_when_stalled", 32'(o_tready), 0);
            if (prev_stall) begin
                check("stall_valid_held", 32'(o_tvalid), 1);
                check("stall_data_held", 32'(o_tdata), 32'(prev_data));
                check("stall_last_held", 32'(o_tlast), 32'(prev_last));
            end
            if (watch_en) check("idle_source_tready", 32'(o_tready & watch_mask), 0);
            prev_stall = o_tvalid && !i_tready;
            prev_data  = o_tdata;
            prev_last  = o_tlast;

            if (o_tvalid && i_tready) begin
                if (!in_pkt) begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && exp_q[k].size() > 0 && exp_q[k][0].first &&
                            exp_q[k][0].data == o_tdata) begin
                            found   = 1'b1;
                            cur_src = k;
                        end
                    end
                    check("packet_start_known", 32'(found), 1);
                    if (found) begin
                        in_pkt = 1'b1;
                        pkt_order.push_back(cur_src);
                    end
                end
                if (in_pkt) begin
                    check("expected_beat_available", 32'(exp_q[cur_src].size() > 0), 1);
                    if (exp_q[cur_src].size() > 0) begin
                        e = exp_q[cur_src].pop_front();
                        check("beat_data", 32'(o_tdata), 32'(e.data));
                        check("beat_last", 32'(o_tlast), 32'(e.last));
                        if (e.last) in_pkt = 1'b0;
                    end
                    beat_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int t;
        int seq [N];

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_tvalid", 32'(o_tvalid), 0);
        check("rst_tready", 32'(o_tready), 0);
        check("rst_grant", 32'(o_grant), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_tdata", 32'(o_tdata), 0);
        check("rst_tlast", 32'(o_tlast), 0);

        // Three-byte packet from source 2 at full sink rate.
        @(negedge clk);
        c0 = cyc;
        beat_cyc.delete();
        pkt_order.delete();
        send_pkt(2, 3, 8'h41);
        @(negedge clk);
        check("p1_arb_busy", 32'(o_busy), 0);
        check("p1_arb_tready", 32'(o_tready), 0);
        @(negedge clk);
        check("p1_grant_busy", 32'(o_busy), 1);
        check("p1_grant_idx", 32'(o_grant), 2);
        check("p1_grant_tready", 32'(o_tready), 32'(4'b0100));
        drain(100);
        check("p1_beat_count", beat_cyc.size(), 3);
        if (beat_cyc.size() == 3) begin
            check("p1_first_latency", beat_cyc[0] - c0, 3);
            check("p1_beat1_gap", beat_cyc[1] - beat_cyc[0], 1);
            check("p1_beat2_gap", beat_cyc[2] - beat_cyc[1], 1);
        end
        check("p1_back_to_arb", 32'(o_busy), 0);

        // All sources continuously requesting two-byte packets.
        do_reset();
        pkt_order.delete();
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < N; k++)
                send_pkt(k, 2, k * 64 + p * 8);
        drain(400);
        check("p2_packet_count", pkt_order.size(), 12);
        if (pkt_order.size() == 12)
            for (int i = 0; i < 12; i++) check("p2_grant_order", pkt_order[i], i % N);

        // Sink stalls during a four-byte packet.
        for (int i = 0; i < 12; i++) tr_pat.push_back((i % 4 == 1 || i % 4 == 2) ? 0 : 1);
        send_pkt(1, 4, 8'h10);
        drain(200);

        // Only sources 1 and 3 request after source 1 was the last owner.
        do_reset();
        send_pkt(1, 1, 8'h20);
        drain(100);
        pkt_order.delete();
        watch_mask = 4'b0101;
        watch_en   = 1'b1;
        send_pkt(1, 2, 8'h30);
        send_pkt(3, 2, 8'hC0);
        send_pkt(1, 2, 8'h38);
        send_pkt(3, 2, 8'hC8);
        drain(200);
        watch_en = 1'b0;
        check("p4_packet_count", pkt_order.size(), 4);
        if (pkt_order.size() == 4)
            for (int i = 0; i < 4; i++) check("p4_grant_order", pkt_order[i], (i % 2 == 0) ? 3 : 1);

        // Asynchronous reset in the middle of a five-byte packet.
        do_reset();
        beat_cyc.delete();
        send_pkt(0, 5, 8'h50);
        t = 0;
        while (beat_cyc.size() < 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("p5_two_beats_seen", 32'(beat_cyc.size() >= 2), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("p5_async_tvalid", 32'(o_tvalid), 0);
        check("p5_async_tready", 32'(o_tready), 0);
        check("p5_async_busy", 32'(o_busy), 0);
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pkt_order.delete();
        send_pkt(1, 1, 8'h71);
        send_pkt(0, 1, 8'h70);
        drain(100);
        check("p5_packet_count", pkt_order.size(), 2);
        if (pkt_order.size() == 2) begin
            check("p5_first_owner", pkt_order[0], 0);
            check("p5_second_owner", pkt_order[1], 1);
        end

        // Single-byte packets from source 0: one beat every two cycles.
        beat_cyc.delete();
        for (int i = 0; i < 6; i++) send_pkt(0, 1, 8'h80 + i);
        drain(100);
        check("p6_beat_count", beat_cyc.size(), 6);
        if (beat_cyc.size() == 6)
            for (int i = 1; i < 6; i++) check("p6_beat_spacing", beat_cyc[i] - beat_cyc[i-1], 2);

        // Randomized traffic with producer and sink stalls.
        rnd_mode = 1'b1;
        for (int k = 0; k < N; k++) seq[k] = 0;
        for (int it = 0; it < 40; it++) begin
            int k;
            int len;
            k   = $urandom_range(0, N - 1);
            len = $urandom_range(1, 5);
            send_pkt(k, len, k * 64 + seq[k]);
            seq[k] = (seq[k] + len) % 64;
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain(3000);
        rnd_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_corescore_stream_arbiter

`default_nettype wire
